// File: rtl/adv_pkg.sv
// Shared definitions for the adventure game: room encoding, the bit
// position of each room in the one-hot room display, and the room count.
// Used by room_fsm, the sword stage and the game top level.
package adv_pkg;

  localparam int NUM_ROOMS = 7;

  typedef enum logic [2:0] {
    CAVE   = 3'd0,
    TUNNEL = 3'd1,
    RIVER  = 3'd2,
    STASH  = 3'd3,
    DEN    = 3'd4,
    VAULT  = 3'd5,
    GRAVE  = 3'd6
  } room_t;

  // Bit index of each room in room_led (bit 0 = CAVE ... bit 6 = GRAVE).
  localparam int LED_CAVE   = 0;
  localparam int LED_TUNNEL = 1;
  localparam int LED_RIVER  = 2;
  localparam int LED_STASH  = 3;
  localparam int LED_DEN    = 4;
  localparam int LED_VAULT  = 5;
  localparam int LED_GRAVE  = 6;

  localparam logic [NUM_ROOMS-1:0] LED_RESET = 7'b0000001;

endpackage

// File: rtl/move_counter.sv
// Saturating up-counter for accepted moves.
//   clk    : clock, counts on rising edge
//   clr_n  : asynchronous active-low clear to zero
//   en     : count enable, one increment per enabled cycle
//   count  : current count, holds at all-ones instead of wrapping
module move_counter #(
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  output logic [MOVE_W-1:0] count
);

  logic [MOVE_W-1:0] count_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (en && (count_reg != {MOVE_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/room_fsm.sv
// Room state machine for the adventure game.
//   clk        : single clock
//   reset      : asynchronous active-low reset (0 = in reset)
//   n,s,e,w    : direction requests, level-sampled every cycle
//   v          : registered "sword held" flag from the sword stage
//   sw         : high while in STASH (sword pickup strobe)
//   room_led   : one-hot current room, bit 0 = CAVE .. bit 6 = GRAVE
//   win, die   : high while in VAULT / GRAVE
//   moves      : count of accepted room changes, saturating
// All outputs come straight from flops; the next room is decoded ahead of
// the register so the outputs reflect the new room one cycle after the
// request, with no combinational path from the inputs.
module room_fsm
  import adv_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 n,
  input  logic                 s,
  input  logic                 e,
  input  logic                 w,
  input  logic                 v,
  output logic                 sw,
  output logic [NUM_ROOMS-1:0] room_led,
  output logic                 win,
  output logic                 die,
  output logic [MOVE_W-1:0]    moves
);

  room_t                room_reg;
  room_t                room_next;
  logic [NUM_ROOMS-1:0] room_led_reg;
  logic [NUM_ROOMS-1:0] led_next;
  logic                 sw_reg;
  logic                 win_reg;
  logic                 die_reg;
  logic                 release_reg;
  logic                 step;
  logic [3:0]           dir;
  logic                 one_dir;

  // Reset release: this flop is cleared asynchronously and sets on the
  // first edge after reset goes high; the room register is the second
  // stage, so the earliest move lands on the second edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      release_reg <= 1'b0;
    end else begin
      release_reg <= 1'b1;
    end
  end

  // A request counts only if exactly one direction is high.
  assign dir     = {n, s, e, w};
  assign one_dir = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);

  always_comb begin
    room_next = room_reg;
    step      = 1'b0;
    if (release_reg) begin
      case (room_reg)
        CAVE: begin
          if (one_dir && e) begin
            room_next = TUNNEL;
            step      = 1'b1;
          end
        end
        TUNNEL: begin
          if (one_dir && s) begin
            room_next = RIVER;
            step      = 1'b1;
          end else if (one_dir && w) begin
            room_next = CAVE;
            step      = 1'b1;
          end
        end
        RIVER: begin
          if (one_dir && n) begin
            room_next = TUNNEL;
            step      = 1'b1;
          end else if (one_dir && w) begin
            room_next = STASH;
            step      = 1'b1;
          end else if (one_dir && e) begin
            room_next = DEN;
            step      = 1'b1;
          end
        end
        STASH: begin
          if (one_dir && e) begin
            room_next = RIVER;
            step      = 1'b1;
          end
        end
        // DEN is a one-cycle pass-through decided by the sword; the exit
        // is not a player move and is not counted.
        DEN: begin
          room_next = v ? VAULT : GRAVE;
        end
        // VAULT and GRAVE are terminal.
        default: begin
          room_next = room_reg;
        end
      endcase
    end
  end

  // One-hot decode of the next room, registered below.
  for (genvar gi = 0; gi < NUM_ROOMS; gi++) begin : g_led
    assign led_next[gi] = (3'(room_next) == 3'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      room_reg     <= CAVE;
      room_led_reg <= LED_RESET;
      sw_reg       <= 1'b0;
      win_reg      <= 1'b0;
      die_reg      <= 1'b0;
    end else begin
      room_reg     <= room_next;
      room_led_reg <= led_next;
      sw_reg       <= led_next[LED_STASH];
      win_reg      <= led_next[LED_VAULT];
      die_reg      <= led_next[LED_GRAVE];
    end
  end

  move_counter #(
    .MOVE_W (MOVE_W)
  ) u_move_counter (
    .clk   (clk),
    .clr_n (reset),
    .en    (step),
    .count (moves)
  );

  assign room_led = room_led_reg;
  assign sw       = sw_reg;
  assign win      = win_reg;
  assign die      = die_reg;

endmodule

// File: tb/tb_room_fsm.sv
// Scenario bench for room_fsm with a 4-bit move counter and a simple
// sword stage (v latches high the cycle after sw is seen high).
module tb_room_fsm;

  localparam int MW = 4;

  // Room indices as seen on room_led.
  localparam int RC = 0;  // CAVE
  localparam int RT = 1;  // TUNNEL
  localparam int RR = 2;  // RIVER
  localparam int RS = 3;  // STASH
  localparam int RD = 4;  // DEN
  localparam int RV = 5;  // VAULT
  localparam int RG = 6;  // GRAVE

  // Direction codes packed as {n,s,e,w}.
  localparam logic [3:0] DN = 4'b1000;
  localparam logic [3:0] DS = 4'b0100;
  localparam logic [3:0] DE = 4'b0010;
  localparam logic [3:0] DW = 4'b0001;
  localparam logic [3:0] D0 = 4'b0000;

  typedef struct packed {
    logic [6:0]    led;
    logic          sw;
    logic          win;
    logic          die;
    logic [MW-1:0] moves;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic          v;
  logic          sw;
  logic [6:0]    room_led;
  logic          win, die;
  logic [MW-1:0] moves;

  int    n_vec = 0;
  int    n_err = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  // Sword stage: picks the sword up once sw has been seen.
  logic v_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v_reg <= 1'b0;
    else if (sw) v_reg <= 1'b1;
  end
  assign v = v_reg;

  room_fsm #(.MOVE_W(MW)) dut (
    .clk      (clk),
    .reset    (reset),
    .n        (n),
    .s        (s),
    .e        (e),
    .w        (w),
    .v        (v),
    .sw       (sw),
    .room_led (room_led),
    .win      (win),
    .die      (die),
    .moves    (moves)
  );

  function automatic snap_t exp_of(int idx, int mv);
    snap_t r;
    r.led   = 7'(1 << idx);
    r.sw    = (idx == RS);
    r.win   = (idx == RV);
    r.die   = (idx == RG);
    r.moves = MW'(mv);
    return r;
  endfunction

  function automatic snap_t observed();
    return {room_led, sw, win, die, moves};
  endfunction

  // Reset with release on a falling edge; returns just after the first
  // rising edge, so stimulus driven next is sampled on the second edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {n, s, e, w} = D0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    snap_t got, want;
    #3 reset = 1'b0;
    exp_q.push_back(exp_of(RC, 0));
    #1 got = observed();
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_immediate got=%h want=%h", got, want);
    end else $display("vec reset_immediate ok %h", got);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {n, s, e, w} = D0;
      exp_q.push_back(exp_of(RC, 0));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_idle[%0d] got=%h want=%h", i, got, want);
      end else $display("vec reset_idle[%0d] ok %h", i, got);
    end
  endtask

  task automatic test_win_path();
    logic [3:0] dirs [9] = '{DE, DS, DW, DE, DE, DN, D0, DE, DN};
    int         rooms[9] = '{RT, RR, RS, RR, RD, RV, RV, RV, RV};
    int         mvs  [9] = '{1,  2,  3,  4,  5,  5,  5,  5,  5};
    snap_t got, want;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      {n, s, e, w} = dirs[i];
      exp_q.push_back(exp_of(rooms[i], mvs[i]));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL win_path[%0d] got=%h want=%h", i, got, want);
      end else $display("vec win_path[%0d] ok %h", i, got);
    end
  endtask

  task automatic test_death_path();
    logic [3:0] dirs [8] = '{DE, DS, DE, DS, DN, DS, DE, DW};
    int         rooms[8] = '{RT, RR, RD, RG, RG, RG, RG, RG};
    int         mvs  [8] = '{1,  2,  3,  3,  3,  3,  3,  3};
    snap_t got, want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {n, s, e, w} = dirs[i];
      exp_q.push_back(exp_of(rooms[i], mvs[i]));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL death_path[%0d] got=%h want=%h", i, got, want);
      end else $display("vec death_path[%0d] ok %h", i, got);
    end
  endtask

  // Illegal and multi-direction requests, then level-held requests.
  task automatic test_illegal_and_held();
    logic [3:0] dirs [19] = '{DE, DS, DN | DE, D0, DN, DW, DW, DS, 4'b1111,
                              DE, DE, DS, DS, DW, DW, DE, DE, DE, DE};
    int         rooms[19] = '{RT, RR, RR, RR, RT, RC, RC, RC, RC,
                              RT, RT, RR, RR, RS, RS, RR, RD, RV, RV};
    int         mvs  [19] = '{1,  2,  2,  2,  3,  4,  4,  4,  4,
                              5,  5,  6,  6,  7,  7,  8,  9,  9,  9};
    snap_t got, want;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      {n, s, e, w} = dirs[i];
      exp_q.push_back(exp_of(rooms[i], mvs[i]));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL illegal_held[%0d] got=%h want=%h", i, got, want);
      end else $display("vec illegal_held[%0d] ok %h", i, got);
    end
  endtask

  task automatic test_saturate();
    snap_t got, want;
    int    mv;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      {n, s, e, w} = (i % 2 == 0) ? DE : DW;
      mv = (i + 1 > 15) ? 15 : i + 1;
      exp_q.push_back(exp_of((i % 2 == 0) ? RT : RC, mv));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL saturate[%0d] got=%h want=%h", i, got, want);
      end else $display("vec saturate[%0d] ok %h", i, got);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] dirs [3] = '{DE, DS, DW};
    int         rooms[3] = '{RT, RR, RS};
    snap_t got, want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {n, s, e, w} = dirs[i];
      exp_q.push_back(exp_of(rooms[i], i + 1));
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL async_setup[%0d] got=%h want=%h", i, got, want);
      end else $display("vec async_setup[%0d] ok %h", i, got);
    end
    // Reset mid-cycle while in STASH: outputs clear before the next edge.
    {n, s, e, w} = D0;
    #3 reset = 1'b0;
    exp_q.push_back(exp_of(RC, 0));
    #1 got = observed();
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL async_clear got=%h want=%h", got, want);
    end else $display("vec async_clear ok %h", got);
    // Release with e held: first edge ignored, second edge moves.
    @(negedge clk);
    reset = 1'b1;
    {n, s, e, w} = DE;
    exp_q.push_back(exp_of(RC, 0));
    exp_q.push_back(exp_of(RT, 1));
    exp_q.push_back(exp_of(RT, 1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 got = observed();
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL async_release[%0d] got=%h want=%h", i, got, want);
      end else $display("vec async_release[%0d] ok %h", i, got);
    end
    {n, s, e, w} = D0;
  endtask

  initial begin
    test_reset();
    test_win_path();
    test_death_path();
    test_illegal_and_held();
    test_saturate();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
